// File: rtl/des_pkg.sv
// Shared constants and helpers for the time-multiplexed DES S-box layer:
// S1..S8 tables, P permutation indices, FSM states and the lookup function.
package des_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // One 256-bit row-major table per S-box; entry 0 (row 0, column 0) sits in the top nibble.
    localparam logic [0:7][255:0] SBOX_TAB = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Zero-based P source positions, MSB-first numbering (bit 0 = out_q[31]).
    localparam logic [0:31][4:0] P_IDX = {
        5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
        5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
        5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
        5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
    };

    function automatic logic [3:0] sbox_lookup(input logic [2:0] sel, input logic [5:0] b);
        logic [5:0] idx;
        idx = {b[5], b[0], b[4:1]};
        return SBOX_TAB[sel][(63 - int'(idx)) * 4 +: 4];
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31 - i] = x[31 - int'(P_IDX[i])];
        return y;
    endfunction

endpackage

// File: rtl/des_sbox_rom.sv
// Single combinational S-box: sel picks S1..S8 (0..7), addr is the 6-bit input.
module des_sbox_rom
    import des_pkg::*;
(
    input  logic [2:0] sel,
    input  logic [5:0] addr,
    output logic [3:0] dout
);

    assign dout = sbox_lookup(sel, addr);

endmodule

// File: rtl/des_sbox_seq.sv
// Sequential DES S-box layer, LANES S-boxes per cycle, valid/ready on both sides.
// Define DES_SBOX_PERM_EN to route the result through the DES P permutation.
module des_sbox_seq
    import des_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int STEPS = 8 / LANES;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $fatal(1, "des_sbox_seq: LANES must be 1, 2, 4 or 8");
    end

    state_e        state_q;
    logic [47:0]   in_q;
    logic [31:0]   out_q, out_d;
    logic [SW-1:0] step_q;
    logic          in_ready_q, out_valid_q, busy_q;

    logic [2:0] lane_sel  [LANES];
    logic [5:0] lane_addr [LANES];
    logic [3:0] lane_dout [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_sel[i]  = 3'(int'(step_q) * LANES + i);
        assign lane_addr[i] = in_q[(7 - int'(lane_sel[i])) * 6 +: 6];
        des_sbox_rom u_rom (
            .sel  (lane_sel[i]),
            .addr (lane_addr[i]),
            .dout (lane_dout[i])
        );
    end

    always_comb begin
        out_d = out_q;
        for (int i = 0; i < LANES; i++) out_d[(7 - int'(lane_sel[i])) * 4 +: 4] = lane_dout[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_q        <= '0;
            out_q       <= '0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    in_q       <= in_data;
                    step_q     <= '0;
                    state_q    <= RUN;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                RUN: begin
                    out_q <= out_d;
                    if (step_q == SW'(STEPS - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

`ifdef DES_SBOX_PERM_EN
    assign out_data = p_perm(out_q);
`else
    assign out_data = out_q;
`endif

endmodule

// File: tb/tb_des_sbox_seq.sv
// Directed bench for des_sbox_seq: LANES=8/1/2 instances, vector table, S7 sweep,
// backpressure and mid-run reset sequences.
module tb_des_sbox_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv   [3];
    logic [47:0] id   [3];
    logic        ordy [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        bz   [3];
    logic [31:0] od   [3];

    int pass_cnt = 0;
    int chk_cnt  = 0;

    des_sbox_seq #(.LANES(8)) u_l8 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bz[0]));
    des_sbox_seq #(.LANES(1)) u_l1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bz[1]));
    des_sbox_seq #(.LANES(2)) u_l2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .busy(bz[2]));

    typedef struct {
        int          d;
        logic [47:0] din;
        logic [31:0] raw;
        int          lat;
    } vec_t;

    vec_t vt [8];

    // S7 rows, hand transcribed from FIPS 46-3; column 0 in the top nibble.
    logic [63:0] s7_row [4];

    function automatic logic [31:0] exp_of(input logic [31:0] raw);
`ifdef DES_SBOX_PERM_EN
        int p1 [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31 - i] = raw[32 - p1[i]];
        return y;
`else
        return raw;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic run_word(input int d, input logic [47:0] din, input logic [31:0] exp,
                            input int lat, input string nm);
        int cyc;
        bit rdy_bad;
        @(negedge clk);
        iv[d] = 1'b1; id[d] = din; ordy[d] = 1'b1;
        chk({nm, "_rdy_in"}, 64'(ir[d]), 64'd1);
        @(posedge clk); #1;
        iv[d] = 1'b0; id[d] = ~din;
        cyc = 0; rdy_bad = 0;
        while (!ov[d] && cyc < 20) begin
            if (ir[d] || !bz[d]) rdy_bad = 1;
            @(posedge clk); #1;
            cyc++;
        end
        if (ir[d] || !bz[d]) rdy_bad = 1;
        chk({nm, "_lat"}, 64'(cyc), 64'(lat));
        chk({nm, "_data"}, 64'(od[d]), 64'(exp));
        chk({nm, "_busy_rdy"}, 64'(rdy_bad), 64'd0);
        @(posedge clk); #1;
        chk({nm, "_idle"}, {62'd0, ir[d], ov[d]}, 64'b10);
    endtask

    initial begin
        logic [31:0] held;
        logic [5:0]  a;
        logic [3:0]  nib;

        s7_row[0] = 64'h4B2EF08D3C975A61;
        s7_row[1] = 64'hD0B7491AE35C2F86;
        s7_row[2] = 64'h14BDC37EAF680592;
        s7_row[3] = 64'h6BD814A7950FE23C;

        vt[0] = '{0, 48'h000000000000, 32'hEFA72C4D, 1};
        vt[1] = '{1, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 8};
        vt[2] = '{2, 48'h000000000000, 32'hEFA72C4D, 4};
        vt[3] = '{2, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 4};
        vt[4] = '{0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB, 1};
        vt[5] = '{1, 48'h000000000000, 32'hEFA72C4D, 8};
        vt[6] = '{2, 48'h0000000000C0, 32'hEFA72C1D, 4};  // S7 addr 0x03: row 1 col 1 = 0
        vt[6].raw = 32'hEFA72C0D;
        vt[7] = '{2, 48'h000000000FC0, 32'hEFA72CCD, 4};  // S7 addr 0x3F -> 12

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b0; end
        iv[2] = 1'b1; id[2] = 48'hFFFFFFFFFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; iv[2] = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_state%0d", k), {61'd0, ir[k], ov[k], bz[k]}, 64'b100);
            chk($sformatf("reset_data%0d", k), 64'(od[k]), 64'd0);
        end

        for (int v = 0; v < 8; v++)
            run_word(vt[v].d, vt[v].din, exp_of(vt[v].raw), vt[v].lat, $sformatf("vec%0d", v));

        // Full S7 sweep on the two-lane instance.
        for (int s = 0; s < 64; s++) begin
            a   = 6'(s);
            nib = s7_row[{a[5], a[0]}][(15 - int'(a[4:1])) * 4 +: 4];
            run_word(2, {36'd0, a, 6'd0}, exp_of({24'hEFA72C, nib, 4'hD}), 4,
                     $sformatf("s7_%02h", s));
        end

        // Backpressure: result must hold and a second word must wait.
        @(negedge clk);
        iv[2] = 1'b1; id[2] = 48'h000000000FC0; ordy[2] = 1'b0;
        @(posedge clk); #1;
        id[2] = 48'hFFFFFFFFFFFF;
        repeat (4) @(posedge clk); #1;
        chk("bp_valid", 64'(ov[2]), 64'd1);
        held = od[2];
        chk("bp_first", 64'(held), 64'(exp_of(32'hEFA72CCD)));
        begin
            bit bp_bad = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (od[2] !== held || ir[2] || !ov[2] || !bz[2]) bp_bad = 1;
            end
            chk("bp_hold", 64'(bp_bad), 64'd0);
        end
        @(negedge clk);
        ordy[2] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {61'd0, ir[2], ov[2], bz[2]}, 64'b100);
        @(posedge clk); #1;
        iv[2] = 1'b0;
        chk("bp_second_acc", {62'd0, ir[2], bz[2]}, 64'b01);
        begin
            int cyc = 0;
            while (!ov[2] && cyc < 20) begin @(posedge clk); #1; cyc++; end
            chk("bp_second_lat", 64'(cyc), 64'd4);
            chk("bp_second_data", 64'(od[2]), 64'(exp_of(32'hD9CE3DCB)));
        end
        @(posedge clk); #1;

        // Reset on the second RUN cycle discards the word.
        @(negedge clk);
        iv[2] = 1'b1; id[2] = 48'hFFFFFFFFFFFF;
        @(posedge clk); #1;
        iv[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_state", {61'd0, ir[2], ov[2], bz[2]}, 64'b100);
        begin
            bit spur = 0;
            repeat (6) begin @(posedge clk); #1; if (ov[2] || bz[2]) spur = 1; end
            chk("rst_mid_spurious", 64'(spur), 64'd0);
        end
        run_word(2, 48'h000000000040, exp_of(32'hEFA72CDD), 4, "rst_after");  // S7 0x01 -> 13

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/des_sbox_seq.md
Name: des_sbox_seq

Overview:
- Sequential DES S-box substitution layer. Maps a 48-bit expanded/key-mixed word to the 32-bit S1..S8 output.
- Time-multiplexed: LANES S-boxes are evaluated per cycle, which trades area for latency.
- Sits between the key-mix XOR and the P permutation in the round datapath of the TDES engine.
- Valid/ready on both sides.

Parameters:
- LANES, 2, S-boxes evaluated per cycle. Legal values 1, 2, 4, 8. Any other value is a fatal elaboration error.
- STEPS, 8/LANES, derived localparam, not overridable. Number of compute cycles per word.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word
- in_data  in  48  [47:42]=S1 address … [5:0]=S8 address
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  32  [31:28]=S1 result … [3:0]=S8 result
- busy  out  1  high in RUN or DONE

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- S-box addressing: each 6-bit address b[5:0] selects row {b5,b0} and column b[4:1], per FIPS 46-3.
  - Example: S7 address 0x00 -> 4, 0x01 -> 13, 0x3F -> 12.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data into in_q, clear step counter, go to RUN.
  - RUN: in_ready=0. Each cycle, S-boxes step*LANES … step*LANES+LANES-1 are looked up from in_q and written into their out_q nibbles. When step==STEPS-1, go to DONE; otherwise step+1.
  - DONE: out_valid=1 and out_data=out_q, held stable until out_ready. On out_ready, go to IDLE.
- Latency: out_valid rises STEPS cycles after the accepting edge (LANES=8: 1 cycle; LANES=1: 8 cycles).
- Throughput: at most one word per STEPS+2 cycles. No overlap between words.
- in_ready is a registered-state decode. It never depends combinationally on out_ready.
- in_data is sampled only at the accept edge. Input changes during RUN or DONE have no effect.
- out_data is stable while out_valid=1 and out_ready=0. Its value outside DONE is don't-care but must not be X after reset.
- Step counter width is clog2(STEPS), minimum 1 bit. It resets to 0 on every accept.
- Reset values: state=IDLE, in_ready=1 (first cycle after reset release), out_valid=0, busy=0, out_q=0, in_q=0, step=0.
- Reset mid-operation (RUN or DONE): the word is discarded. Next cycle is IDLE with out_valid=0 and no spurious output.
- in_valid in IDLE on the same cycle as rst: ignored, not captured.
- out_ready while not in DONE: ignored.

Optional Feature:
- Macro: DES_SBOX_PERM_EN
- Defined: out_data is P(out_q), the DES 32-bit P permutation, applied as pure wiring on the output register path. Latency and handshake are unchanged.
- Undefined: out_data = out_q, raw S1..S8 concatenation.

Decomposition:
- Package des_pkg holds:
  - the 8×64×4-bit S-box constant tables,
  - the P permutation index constant,
  - the FSM state enum (IDLE/RUN/DONE),
  - the function computing the row/column-indexed lookup.
- One sub-module: des_sbox_rom (inputs: sel[2:0], addr[5:0]; output: dout[3:0]; combinational), instantiated LANES times.
  - Lane i gets sel = step*LANES+i and the matching 6-bit slice of in_q.

Test Plan:
- LANES=8, in_data=48'h000000000000, out_ready=1 -> out_valid exactly 1 cycle after accept, out_data=32'hEFA72C4D.
- LANES=1, in_data=48'hFFFFFFFFFFFF -> out_valid exactly 8 cycles after accept, out_data=32'hD9CE3DCB; in_ready=0 throughout RUN/DONE.
- LANES=2, S7 field swept 0x00..0x3F with other fields 0 -> out_data[7:4] matches the S7 table (0x00->4, 0x02->11, 0x3F->12); other nibbles constant.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data stable, in_ready=0, second in_valid not accepted. Then out_ready=1 -> IDLE the next cycle, second word accepted.
- Reset asserted on the 2nd RUN cycle (LANES=2) -> next cycle state IDLE, out_valid=0, in_ready=1. The following word produces the correct result.
- DES_SBOX_PERM_EN defined, in_data=0 -> out_data equals P(32'hEFA72C4D) per the reference model; latency identical to the undefined build.
